// File: rtl/fft_iter_frame_sched.sv
// Ping-pong frame scheduler for an iterative FFT core.
// Two banks cycle FREE -> FULL -> DONE -> FREE. The loader fills one bank while
// the core computes on the other and the drain port empties whichever is DONE.
// The load, compute and drain pointers each advance 0 -> 1 -> 0 in strict order.
// Optional build macro: FFT_SCHED_BITREV_EN. When defined, RD_ADDR is the base-4
// digit reversal of the read index (radix-4 output order). N_WL must be even.
module fft_iter_frame_sched #(
    parameter int unsigned N_WL = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [N_WL-1:0] WR_ADDR,
    output logic            LOAD_BANK,
    output logic            FFT_START,
    output logic            FFT_BANK,
    input  logic            FFT_DONE,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [N_WL-1:0] RD_ADDR,
    output logic            OUT_BANK,
    output logic            BUSY,
    output logic            ERR
);

    typedef enum logic [1:0] {
        StFree,
        StFull,
        StDone
    } bank_st_e;

    typedef enum logic {
        CoreIdle,
        CoreBusy
    } core_st_e;

    bank_st_e        status_q [2];
    bank_st_e        status_d [2];
    core_st_e        core_q, core_d;
    logic            ld_q, ld_d;
    logic            cmp_q, cmp_d;
    logic            out_q, out_d;
    logic [N_WL-1:0] wr_addr_q, wr_addr_d;
    logic [N_WL-1:0] rd_idx_q, rd_idx_d;
    logic            err_q, err_d;

    logic            in_ready;
    logic            out_valid;
    logic            fft_start;
    logic            accept;
    logic            drain;

    // Scheduling state register; synchronous active-low reset discards any frames in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            status_q[0] <= StFree;
            status_q[1] <= StFree;
            core_q      <= CoreIdle;
            ld_q        <= 1'b0;
            cmp_q       <= 1'b0;
            out_q       <= 1'b0;
            wr_addr_q   <= '0;
            rd_idx_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            status_q[0] <= status_d[0];
            status_q[1] <= status_d[1];
            core_q      <= core_d;
            ld_q        <= ld_d;
            cmp_q       <= cmp_d;
            out_q       <= out_d;
            wr_addr_q   <= wr_addr_d;
            rd_idx_q    <= rd_idx_d;
            err_q       <= err_d;
        end
    end

    // Handshakes, start pulse and next-state; each status write targets a distinct bank.
    always_comb begin
        status_d[0] = status_q[0];
        status_d[1] = status_q[1];
        core_d      = core_q;
        ld_d        = ld_q;
        cmp_d       = cmp_q;
        out_d       = out_q;
        wr_addr_d   = wr_addr_q;
        rd_idx_d    = rd_idx_q;
        err_d       = err_q;

        in_ready  = EN && (status_q[ld_q] == StFree);
        out_valid = EN && (status_q[out_q] == StDone);
        fft_start = EN && (core_q == CoreIdle) && (status_q[cmp_q] == StFull);
        accept    = IN_VALID && in_ready;
        drain     = out_valid && OUT_READY;

        if (accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == '1) begin
                status_d[ld_q] = StFull;
                ld_d           = ~ld_q;
            end
        end

        if (fft_start) begin
            core_d = CoreBusy;
        end

        // Completion is honoured even with EN low so a pulse is never lost.
        if (FFT_DONE) begin
            if (core_q == CoreBusy) begin
                status_d[cmp_q] = StDone;
                core_d          = CoreIdle;
                cmp_d           = ~cmp_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (drain) begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == '1) begin
                status_d[out_q] = StFree;
                out_d           = ~out_q;
            end
        end
    end

`ifdef FFT_SCHED_BITREV_EN
    // Read address is the read index with its base-4 digits in reverse order.
    always_comb begin
        RD_ADDR = '0;
        for (int unsigned d = 0; d < N_WL / 2; d++) begin
            RD_ADDR[2*d +: 2] = rd_idx_q[N_WL-2-2*d +: 2];
        end
    end
`else
    // Read address follows the read index directly (natural order).
    always_comb begin
        RD_ADDR = rd_idx_q;
    end
`endif

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign FFT_START = fft_start;
    assign WR_ADDR   = wr_addr_q;
    assign LOAD_BANK = ld_q;
    assign FFT_BANK  = cmp_q;
    assign OUT_BANK  = out_q;
    assign BUSY      = (core_q == CoreBusy);
    assign ERR       = err_q;

endmodule
